// File: rtl/execute.sv
// EX stage: operand forwarding, 16-bit ALU, branch/jump resolution and the EX/MEM
// pipeline register, including the wrong-path squash after a taken redirect.
module execute (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Rd1_IDEX,
  input  logic [15:0] Rd2_IDEX,
  input  logic [15:0] Imm_IDEX,
  input  logic [15:0] PC2_IDEX,
  input  logic [3:0]  ALUOp_IDEX,
  input  logic        ALUSrc_IDEX,
  input  logic [2:0]  BrType_IDEX,
  input  logic        Jump_IDEX,
  input  logic        JumpReg_IDEX,
  input  logic        Link_IDEX,
  input  logic        MemWrite_IDEX,
  input  logic        MemRead_IDEX,
  input  logic        MemtoReg_IDEX,
  input  logic        RegWrite_IDEX,
  input  logic        Dump_IDEX,
  input  logic        halt_IDEX,
  input  logic [2:0]  WrR_IDEX,
  input  logic [1:0]  fwdA,
  input  logic [1:0]  fwdB,
  input  logic [15:0] WrD_WB,
  input  logic        flush_IDEX,
  output logic [15:0] ALUO_EXMEM,
  output logic [15:0] Rd2_EXMEM,
  output logic        takeBranch_EXMEM,
  output logic [15:0] BrTarget_EXMEM,
  output logic        MemWrite_EXMEM,
  output logic        MemRead_EXMEM,
  output logic        MemtoReg_EXMEM,
  output logic        RegWrite_EXMEM,
  output logic        Dump_EXMEM,
  output logic        halt_EXMEM,
  output logic [2:0]  WrR_EXMEM
);

  localparam int unsigned DW = 16;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_WB    = 2'b10;

  logic [DW-1:0] aluo_q, rd2_q, tgt_q;
  logic [DW-1:0] aluo_d, rd2_d, tgt_d;
  logic          tb_q, tb_d;
  logic [5:0]    ctrl_q, ctrl_d;     // {MemWrite, MemRead, MemtoReg, RegWrite, Dump, halt}
  logic [2:0]    wrr_q;

  logic [DW-1:0] a, bf, b, alu, btr;
  logic [31:0]   dbl, rol_w, ror_w;
  logic [DW:0]   sum17;
  logic [3:0]    sh;
  logic          cond, take, bubble;

  // Forwarding muxes; the reserved select falls back to the register value.
  always_comb begin
    a = Rd1_IDEX;
    if (fwdA == FWD_EXMEM)   a = aluo_q;
    else if (fwdA == FWD_WB) a = WrD_WB;
    bf = Rd2_IDEX;
    if (fwdB == FWD_EXMEM)   bf = aluo_q;
    else if (fwdB == FWD_WB) bf = WrD_WB;
    b = ALUSrc_IDEX ? Imm_IDEX : bf;
  end

  always_comb begin
    sh    = b[3:0];
    dbl   = {a, a};
    rol_w = dbl >> (5'd16 - 5'(sh));
    ror_w = dbl >> 5'(sh);
    sum17 = {1'b0, a} + {1'b0, b};
    btr   = '0;
    for (int i = 0; i < 16; i++) btr[i] = a[15-i];
  end

  always_comb begin
    alu = '0;
    case (ALUOp_IDEX)
      4'd0:  alu = a + b;
      4'd1:  alu = b - a;
      4'd2:  alu = a ^ b;
      4'd3:  alu = a & ~b;
      4'd4:  alu = rol_w[15:0];
      4'd5:  alu = a << sh;
      4'd6:  alu = ror_w[15:0];
      4'd7:  alu = $unsigned($signed(a) >>> sh);
      4'd8:  alu = {15'd0, a == b};
      4'd9:  alu = {15'd0, $signed(a) <  $signed(b)};
      4'd10: alu = {15'd0, $signed(a) <= $signed(b)};
      4'd11: alu = {15'd0, sum17[16]};
      4'd12: alu = btr;
      4'd13: alu = b;
      4'd14: alu = {a[7:0], b[7:0]};
      default: alu = a;
    endcase
  end

  // Branch resolution; a redirect in EX/MEM makes the current instruction wrong-path.
  always_comb begin
    case (BrType_IDEX[1:0])
      2'b00:   cond = (a == '0);
      2'b01:   cond = (a != '0);
      2'b10:   cond = a[15];
      default: cond = ~a[15];
    endcase
    take   = Jump_IDEX | (BrType_IDEX[2] & cond);
    bubble = flush_IDEX | tb_q;
    aluo_d = Link_IDEX ? PC2_IDEX : alu;
    rd2_d  = bf;
    tgt_d  = (JumpReg_IDEX ? a : PC2_IDEX) + Imm_IDEX;
    tb_d   = take & ~bubble;
    ctrl_d = {MemWrite_IDEX & ~bubble, MemRead_IDEX & ~bubble, MemtoReg_IDEX,
              RegWrite_IDEX & ~bubble, Dump_IDEX & ~bubble, halt_IDEX & ~bubble};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aluo_q <= '0;
      rd2_q  <= '0;
      tgt_q  <= '0;
      tb_q   <= 1'b0;
      ctrl_q <= '0;
      wrr_q  <= '0;
    end else begin
      aluo_q <= aluo_d;
      rd2_q  <= rd2_d;
      tgt_q  <= tgt_d;
      tb_q   <= tb_d;
      ctrl_q <= ctrl_d;
      wrr_q  <= WrR_IDEX;
    end
  end

  assign ALUO_EXMEM       = aluo_q;
  assign Rd2_EXMEM        = rd2_q;
  assign takeBranch_EXMEM = tb_q;
  assign BrTarget_EXMEM   = tgt_q;
  assign MemWrite_EXMEM   = ctrl_q[5];
  assign MemRead_EXMEM    = ctrl_q[4];
  assign MemtoReg_EXMEM   = ctrl_q[3];
  assign RegWrite_EXMEM   = ctrl_q[2];
  assign Dump_EXMEM       = ctrl_q[1];
  assign halt_EXMEM       = ctrl_q[0];
  assign WrR_EXMEM        = wrr_q;

endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for execute: the driver pushes hand-computed EX/MEM contents per
// edge, and a negedge monitor pops and compares the selected fields.
module tb_execute;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Rd1, Rd2, Imm, PC2, WrD;
  logic [3:0]  ALUOp;
  logic        ALUSrc, Jump, JumpReg, Link, MemWrite, MemRead, MemtoReg, RegWrite, Dump, halt, flush;
  logic [2:0]  BrType, WrR;
  logic [1:0]  fwdA, fwdB;

  logic [15:0] o_aluo, o_rd2, o_tgt;
  logic        o_tb, o_mw, o_mr, o_m2r, o_rw, o_dump, o_halt;
  logic [2:0]  o_wrr;

  execute dut (
    .clk(clk), .rst(rst),
    .Rd1_IDEX(Rd1), .Rd2_IDEX(Rd2), .Imm_IDEX(Imm), .PC2_IDEX(PC2),
    .ALUOp_IDEX(ALUOp), .ALUSrc_IDEX(ALUSrc), .BrType_IDEX(BrType),
    .Jump_IDEX(Jump), .JumpReg_IDEX(JumpReg), .Link_IDEX(Link),
    .MemWrite_IDEX(MemWrite), .MemRead_IDEX(MemRead), .MemtoReg_IDEX(MemtoReg),
    .RegWrite_IDEX(RegWrite), .Dump_IDEX(Dump), .halt_IDEX(halt),
    .WrR_IDEX(WrR), .fwdA(fwdA), .fwdB(fwdB), .WrD_WB(WrD), .flush_IDEX(flush),
    .ALUO_EXMEM(o_aluo), .Rd2_EXMEM(o_rd2), .takeBranch_EXMEM(o_tb),
    .BrTarget_EXMEM(o_tgt), .MemWrite_EXMEM(o_mw), .MemRead_EXMEM(o_mr),
    .MemtoReg_EXMEM(o_m2r), .RegWrite_EXMEM(o_rw), .Dump_EXMEM(o_dump),
    .halt_EXMEM(o_halt), .WrR_EXMEM(o_wrr)
  );

  always #5 clk = ~clk;

  // Check mask bits: 0 aluo, 1 rd2, 2 takeBranch, 3 target, 4 control, 5 wrr.
  localparam logic [5:0] M_ALL  = 6'b111111;
  localparam logic [5:0] M_ALU  = 6'b010101;
  localparam logic [5:0] M_CTRL = 6'b010100;
  localparam logic [5:0] M_BR   = 6'b011100;

  typedef struct {
    string       name;
    logic [5:0]  m;
    logic [15:0] aluo, rd2, tgt;
    logic        tb;
    logic [5:0]  ctrl;   // {MemWrite, MemRead, MemtoReg, RegWrite, Dump, halt}
    logic [2:0]  wrr;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      logic [5:0] act_ctrl;
      e = sbq.pop_front();
      act_ctrl = {o_mw, o_mr, o_m2r, o_rw, o_dump, o_halt};
      if (e.m[0]) begin
        total++;
        if (o_aluo !== e.aluo) begin bad++; $display("FAIL %s aluo: got %h want %h", e.name, o_aluo, e.aluo); end
      end
      if (e.m[1]) begin
        total++;
        if (o_rd2 !== e.rd2) begin bad++; $display("FAIL %s rd2: got %h want %h", e.name, o_rd2, e.rd2); end
      end
      if (e.m[2]) begin
        total++;
        if (o_tb !== e.tb) begin bad++; $display("FAIL %s takeBranch: got %b want %b", e.name, o_tb, e.tb); end
      end
      if (e.m[3]) begin
        total++;
        if (o_tgt !== e.tgt) begin bad++; $display("FAIL %s target: got %h want %h", e.name, o_tgt, e.tgt); end
      end
      if (e.m[4]) begin
        total++;
        if (act_ctrl !== e.ctrl) begin bad++; $display("FAIL %s ctrl: got %b want %b", e.name, act_ctrl, e.ctrl); end
      end
      if (e.m[5]) begin
        total++;
        if (o_wrr !== e.wrr) begin bad++; $display("FAIL %s wrr: got %0d want %0d", e.name, o_wrr, e.wrr); end
      end
    end
  end

  task automatic clr();
    rst = 1'b0; Rd1 = '0; Rd2 = '0; Imm = '0; PC2 = '0; WrD = '0; ALUOp = 4'd0;
    ALUSrc = 1'b0; Jump = 1'b0; JumpReg = 1'b0; Link = 1'b0; MemWrite = 1'b0;
    MemRead = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0; Dump = 1'b0; halt = 1'b0;
    flush = 1'b0; BrType = 3'b000; WrR = 3'd0; fwdA = 2'b00; fwdB = 2'b00;
  endtask

  task automatic issue(input string nm, input logic [5:0] m, input logic [15:0] aluo,
                       input logic [15:0] rd2, input logic tb, input logic [15:0] tgt,
                       input logic [5:0] ctrl, input logic [2:0] wrr);
    exp_t x;
    x.name = nm; x.m = m; x.aluo = aluo; x.rd2 = rd2; x.tb = tb;
    x.tgt = tgt; x.ctrl = ctrl; x.wrr = wrr;
    sbq.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic alu_op(input string nm, input logic [3:0] op, input logic [15:0] ra,
                        input logic [15:0] rb, input logic [15:0] want);
    clr(); ALUOp = op; Rd1 = ra; Rd2 = rb;
    issue(nm, M_ALU, want, '0, 1'b0, '0, 6'b000000, 3'd0);
  endtask

  initial begin
    // Reset with garbage on every input
    for (int i = 0; i < 2; i++) begin
      clr(); rst = 1'b1; Rd1 = 16'hFFFF; Rd2 = 16'hAAAA; Imm = 16'h5555; PC2 = 16'h1234;
      ALUOp = 4'd0; Jump = 1'b1; MemWrite = 1'b1; MemRead = 1'b1; MemtoReg = 1'b1;
      RegWrite = 1'b1; Dump = 1'b1; halt = 1'b1; WrR = 3'd7;
      issue("reset", M_ALL, '0, '0, 1'b0, '0, 6'b000000, 3'd0);
    end
    clr(); Rd1 = 16'h0003; Rd2 = 16'h0004; RegWrite = 1'b1; WrR = 3'd3;
    issue("add_first", M_ALL, 16'h0007, 16'h0004, 1'b0, 16'h0000, 6'b000100, 3'd3);

    alu_op("slt_ovf", 4'd9,  16'h8000, 16'h7FFF, 16'h0001);
    alu_op("sco",     4'd11, 16'hFFFF, 16'h0001, 16'h0001);
    alu_op("ror",     4'd6,  16'h8001, 16'h0001, 16'hC000);
    alu_op("sra",     4'd7,  16'h8000, 16'h000F, 16'hFFFF);
    alu_op("btr",     4'd12, 16'h0001, 16'h0000, 16'h8000);
    alu_op("sub",     4'd1,  16'h0003, 16'h0010, 16'h000D);
    alu_op("rol",     4'd4,  16'h8001, 16'h0004, 16'h0018);
    alu_op("sle_eq",  4'd10, 16'h0005, 16'h0005, 16'h0001);
    alu_op("andn",    4'd3,  16'h00FF, 16'h000F, 16'h00F0);

    // SLBI uses Imm as B, but Rd2_EXMEM still carries the register operand
    clr(); ALUOp = 4'd14; Rd1 = 16'h0012; Imm = 16'h0034; Rd2 = 16'h0055; ALUSrc = 1'b1;
    issue("slbi", M_ALL, 16'h1234, 16'h0055, 1'b0, 16'h0034, 6'b000000, 3'd0);

    // Forwarding from EX/MEM and WB
    alu_op("fwd_prep", 4'd0, 16'h0008, 16'h0008, 16'h0010);
    clr(); Rd1 = 16'h0000; Rd2 = 16'h0099; WrD = 16'h0020; fwdA = 2'b01; fwdB = 2'b10;
    issue("fwd_add", M_ALL, 16'h0030, 16'h0020, 1'b0, 16'h0000, 6'b000000, 3'd0);
    alu_op("fwd_prep2", 4'd0, 16'h0008, 16'h0008, 16'h0010);
    clr(); Rd1 = 16'h0100; Imm = 16'h0002; ALUSrc = 1'b1; Rd2 = 16'h0077; fwdB = 2'b01;
    MemWrite = 1'b1; fwdA = 2'b11;
    issue("fwd_store", M_ALL, 16'h0102, 16'h0010, 1'b0, 16'h0002, 6'b100000, 3'd0);

    // Taken BEQZ, then wrong-path instruction (itself a jump) squashed, then normal
    clr(); BrType = 3'b100; PC2 = 16'h0040; Imm = 16'h0006;
    issue("beqz", M_BR, '0, '0, 1'b1, 16'h0046, 6'b000000, 3'd0);
    clr(); Rd1 = 16'h0001; Rd2 = 16'h0001; RegWrite = 1'b1; MemWrite = 1'b1; Jump = 1'b1;
    issue("squash", M_CTRL, '0, '0, 1'b0, '0, 6'b000000, 3'd0);
    clr(); Rd1 = 16'h0002; Rd2 = 16'h0002; RegWrite = 1'b1; WrR = 3'd5;
    issue("after_sq", M_ALL, 16'h0004, 16'h0002, 1'b0, 16'h0000, 6'b000100, 3'd5);

    clr(); BrType = 3'b101; Rd1 = 16'h0000;
    issue("bnez_nt", M_CTRL, '0, '0, 1'b0, '0, 6'b000000, 3'd0);
    clr(); BrType = 3'b110; Rd1 = 16'h8000; PC2 = 16'h0100; Imm = 16'hFFFE;
    issue("bltz_t", M_BR, '0, '0, 1'b1, 16'h00FE, 6'b000000, 3'd0);
    clr(); BrType = 3'b111; Rd1 = 16'h8000;
    issue("bgez_sq", M_CTRL, '0, '0, 1'b0, '0, 6'b000000, 3'd0);
    clr(); BrType = 3'b111; Rd1 = 16'h8000;
    issue("bgez_nt", M_CTRL, '0, '0, 1'b0, '0, 6'b000000, 3'd0);

    // JALR with link
    clr(); Rd1 = 16'h0100; Imm = 16'h0004; PC2 = 16'h0022; Link = 1'b1; Jump = 1'b1;
    JumpReg = 1'b1; ALUSrc = 1'b1; RegWrite = 1'b1; WrR = 3'd7;
    issue("jalr", M_ALL, 16'h0022, 16'h0000, 1'b1, 16'h0104, 6'b000100, 3'd7);
    clr(); halt = 1'b1;
    issue("jalr_sq_halt", M_CTRL, '0, '0, 1'b0, '0, 6'b000000, 3'd0);

    // Hazard-unit flush, then halt/dump passing through unmodified
    clr(); flush = 1'b1; halt = 1'b1; MemWrite = 1'b1; Dump = 1'b1; MemRead = 1'b1;
    issue("flush", M_CTRL, '0, '0, 1'b0, '0, 6'b000000, 3'd0);
    clr(); halt = 1'b1; Dump = 1'b1; MemtoReg = 1'b1; MemRead = 1'b1;
    issue("halt_pass", M_CTRL, '0, '0, 1'b0, '0, 6'b011011, 3'd0);

    // Reset coincident with a taken jump leaves no pending squash
    clr(); Jump = 1'b1; PC2 = 16'h0010;
    issue("jump", M_BR, '0, '0, 1'b1, 16'h0010, 6'b000000, 3'd0);
    clr(); rst = 1'b1; Jump = 1'b1; RegWrite = 1'b1;
    issue("rst_jump", M_ALL, '0, '0, 1'b0, '0, 6'b000000, 3'd0);
    clr(); Rd1 = 16'h0001; Rd2 = 16'h0002; RegWrite = 1'b1; WrR = 3'd1;
    issue("post_rst", M_ALL, 16'h0003, 16'h0002, 1'b0, 16'h0000, 6'b000100, 3'd1);

    clr();
    repeat (3) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
